lamp_arbiter: RTL

//  Owns the single lamp/tone output pair (LAMP/LAMP_ENA) and shares it between the game controller,
//  a score-readout sequencer (blinks SCORE times) and an optional attract animation. Sits between the

---
 rtl/lamp_arbiter_if.sv | 23 ++
 rtl/lamp_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lamp_arbiter_if.sv
// Lamp arbiter signal bundle: controller/score/attract requests in, lamp drive and status out.
// The master side is the controller; the slave side is the arbiter itself.
interface lamp_arbiter_if;
  logic [1:0] ctrl_out;
  logic       ctrl_ena;
  logic       show_score;
  logic [4:0] score;
  logic       game_active;
  logic [1:0] lamp;
  logic       lamp_ena;
  logic       busy;
  logic [1:0] src;

  modport master (
    output ctrl_out, ctrl_ena, show_score, score, game_active,
    input  lamp, lamp_ena, busy, src
  );

  modport slave (
    input  ctrl_out, ctrl_ena, show_score, score, game_active,
    output lamp, lamp_ena, busy, src
  );
endinterface

// File: rtl/lamp_arbiter.sv
// Shares the lamp/tone output between the game controller, a score blinker and an attract animation.
// Define LAMP_ATTRACT_EN to build the idle timeout and the ATTRACT lamp-stepping owner.
module lamp_arbiter #(
  parameter int TW          = 25,
  parameter int GAP_CYCLES  = 4,
  parameter int ON_CYCLES   = 3_125_000,
  parameter int OFF_CYCLES  = 3_125_000,
  parameter int IDLE_CYCLES = 25_000_000,
  parameter int STEP_CYCLES = 6_250_000
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  lamp_arbiter_if.slave  bus
);

  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
  localparam logic [TW-1:0] OFF_LAST = TW'(OFF_CYCLES - 1);

`ifdef LAMP_ATTRACT_EN
  localparam logic [TW-1:0] IDLE_LAST = TW'(IDLE_CYCLES - 1);
  localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
  typedef enum logic [2:0] {IDLE, CTRL, SCORE_ON, SCORE_OFF, ATTRACT, GAP} state_e;
`else
  typedef enum logic [2:0] {IDLE, CTRL, SCORE_ON, SCORE_OFF, GAP} state_e;
`endif

  state_e        state_q, state_d;
  logic [1:0]    lamp_q, lamp_d;
  logic          lamp_ena_q, lamp_ena_d;
  logic [1:0]    src_q, src_d;
  logic          busy_q, busy_d;
  logic          pend_q, pend_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic [4:0]    blink_q, blink_d;
  logic [4:0]    score_q, score_d;

`ifdef LAMP_ATTRACT_EN
  logic [TW-1:0] idle_q, idle_d;
`else
  logic unused_attract;
  assign unused_attract = bus.game_active ^ (IDLE_CYCLES != STEP_CYCLES);
`endif

  always_comb begin
    state_d    = state_q;
    lamp_d     = lamp_q;
    lamp_ena_d = 1'b0;
    src_d      = 2'd0;
    cnt_d      = cnt_q;
    blink_d    = blink_q;
    pend_d     = pend_q;
    score_d    = score_q;
`ifdef LAMP_ATTRACT_EN
    idle_d     = '0;
`endif
    case (state_q)
      IDLE: begin
        if (bus.ctrl_ena) begin
          state_d    = CTRL;
          lamp_d     = bus.ctrl_out;
          lamp_ena_d = 1'b1;
          src_d      = 2'd1;
        end else if (pend_q) begin
          if (score_q == 5'd0) begin
            pend_d = 1'b0;
          end else begin
            state_d    = SCORE_ON;
            lamp_d     = 2'b00;
            lamp_ena_d = 1'b1;
            src_d      = 2'd2;
            cnt_d      = '0;
            blink_d    = 5'd1;
          end
        end
`ifdef LAMP_ATTRACT_EN
        else if (!bus.show_score && !bus.game_active) begin
          if (idle_q >= IDLE_LAST) begin
            state_d    = ATTRACT;
            lamp_d     = 2'b00;
            lamp_ena_d = 1'b1;
            src_d      = 2'd3;
            cnt_d      = '0;
          end else begin
            idle_d = idle_q + TW'(1);
          end
        end
`endif
      end
      CTRL: begin
        lamp_d     = bus.ctrl_out;
        lamp_ena_d = bus.ctrl_ena;
        if (bus.ctrl_ena) src_d = 2'd1;
        else              state_d = IDLE;
      end
      SCORE_ON: begin
        if (bus.ctrl_ena) begin
          state_d = GAP;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          src_d = 2'd2;
          if (cnt_q == ON_LAST) begin
            state_d = SCORE_OFF;
            cnt_d   = '0;
          end else begin
            lamp_ena_d = 1'b1;
            cnt_d      = cnt_q + TW'(1);
          end
        end
      end
      SCORE_OFF: begin
        if (bus.ctrl_ena) begin
          state_d = GAP;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else if (cnt_q == OFF_LAST) begin
          if (blink_q == score_q) begin
            state_d = IDLE;
            pend_d  = 1'b0;
          end else begin
            state_d    = SCORE_ON;
            blink_d    = blink_q + 5'd1;
            lamp_ena_d = 1'b1;
            src_d      = 2'd2;
            cnt_d      = '0;
          end
        end else begin
          src_d = 2'd2;
          cnt_d = cnt_q + TW'(1);
        end
      end
`ifdef LAMP_ATTRACT_EN
      ATTRACT: begin
        if (bus.ctrl_ena || bus.show_score || bus.game_active) begin
          state_d = GAP;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end else begin
          src_d      = 2'd3;
          lamp_ena_d = 1'b1;
          if (cnt_q == STEP_LAST) begin
            lamp_d = lamp_q + 2'd1;
            cnt_d  = '0;
          end else begin
            cnt_d = cnt_q + TW'(1);
          end
        end
      end
`endif
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          if (bus.ctrl_ena) begin
            state_d    = CTRL;
            lamp_d     = bus.ctrl_out;
            lamp_ena_d = 1'b1;
            src_d      = 2'd1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // A new request is not taken while blinking, nor on the edge a readout starts from pending.
    if (bus.show_score && state_q != SCORE_ON && state_q != SCORE_OFF && state_d != SCORE_ON) begin
      score_d = bus.score;
      pend_d  = 1'b1;
    end

    busy_d = (state_d == SCORE_ON) || (state_d == SCORE_OFF) || (state_d == GAP) || pend_d;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      lamp_q     <= 2'b11;
      lamp_ena_q <= 1'b0;
      src_q      <= 2'd0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      cnt_q      <= '0;
      blink_q    <= 5'd0;
      score_q    <= 5'd0;
`ifdef LAMP_ATTRACT_EN
      idle_q     <= '0;
`endif
    end else begin
      state_q    <= state_d;
      lamp_q     <= lamp_d;
      lamp_ena_q <= lamp_ena_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
      pend_q     <= pend_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      score_q    <= score_d;
`ifdef LAMP_ATTRACT_EN
      idle_q     <= idle_d;
`endif
    end
  end

  assign bus.lamp     = lamp_q;
  assign bus.lamp_ena = lamp_ena_q;
  assign bus.src      = src_q;
  assign bus.busy     = busy_q;

endmodule
